// File: rtl/freelist_free_sched.sv
// freelist_free_sched: buffers up to two commit-time frees per cycle, drains
// one per cycle into the single-ported freelist, and gates rename allocation
// behind a flush-recovery hold while the freelist reinitialises.
module freelist_free_sched #(
  parameter int unsigned PR_BITS  = 6,
  parameter int unsigned FQ_DEPTH = 8,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 cm_free_en,
  input  logic [PR_BITS-1:0]         cm_free_reg0,
  input  logic [PR_BITS-1:0]         cm_free_reg1,
  output logic                       cm_ready,
  input  logic                       ren_req,
  output logic                       ren_gnt,
  output logic [PR_BITS-1:0]         ren_preg,
  output logic                       fl_free_en,
  output logic [PR_BITS-1:0]         fl_free_reg,
  output logic                       fl_alloc_en,
  input  logic [PR_BITS-1:0]         fl_alloc_reg,
  input  logic                       fl_alloc_valid,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  localparam int unsigned PW   = $clog2(FQ_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  logic [HC_W-1:0]     hold_cnt;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PR_BITS-1:0]  mem [FQ_DEPTH];

  logic                push0;
  logic                push1;
  logic                pop;

  // Commit handshake and enqueue/dequeue qualifiers; P0 is never queued
  always_comb begin
    cm_ready = (state == RUN) && ((CW'(FQ_DEPTH) - fq_count) >= CW'(2));
    push0    = cm_ready && cm_free_en[0] && (cm_free_reg0 != '0);
    push1    = cm_ready && cm_free_en[1] && (cm_free_reg1 != '0);
    pop      = (state == RUN) && (fq_count != '0);
  end

  // Rename allocation is only granted in RUN with a non-empty freelist
  always_comb begin
    ren_gnt     = ren_req && fl_alloc_valid && (state == RUN);
    fl_alloc_en = ren_gnt;
    ren_preg    = fl_alloc_reg;
  end

  // FIFO storage; slot 0 lands before slot 1 so commit order is preserved
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push0) mem[wr_ptr] <= cm_free_reg0;
      if (push1) mem[wr_ptr + PW'(push0)] <= cm_free_reg1;
    end
  end

  // Control FSM, FIFO pointers and registered freelist free port
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      hold_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fq_count    <= '0;
      fl_free_en  <= 1'b0;
      fl_free_reg <= '0;
    end else if (flush) begin
      // freelist rebuilds itself, so pending frees are simply discarded
      state      <= HOLD;
      hold_cnt   <= HC_W'(HOLD_CYC - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fq_count   <= '0;
      fl_free_en <= 1'b0;
    end else begin
      if (state == HOLD) begin
        if (hold_cnt == '0) begin
          state <= RUN;
        end else begin
          hold_cnt <= hold_cnt - HC_W'(1);
        end
      end
      wr_ptr     <= wr_ptr + PW'(push0) + PW'(push1);
      rd_ptr     <= rd_ptr + PW'(pop);
      fq_count   <= fq_count + CW'(push0) + CW'(push1) - CW'(pop);
      fl_free_en <= pop;
      if (pop) fl_free_reg <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_freelist_free_sched.sv
// tb_freelist_free_sched: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the free scheduler.
module tb_freelist_free_sched;

  localparam int unsigned PR_BITS  = 6;
  localparam int unsigned FQ_DEPTH = 8;
  localparam int unsigned HOLD_CYC = 2;

  logic                      clk = 1'b0;
  logic                      rst, flush;
  logic [1:0]                cm_free_en;
  logic [PR_BITS-1:0]        cm_free_reg0, cm_free_reg1;
  logic                      cm_ready;
  logic                      ren_req, ren_gnt;
  logic [PR_BITS-1:0]        ren_preg;
  logic                      fl_free_en;
  logic [PR_BITS-1:0]        fl_free_reg;
  logic                      fl_alloc_en;
  logic [PR_BITS-1:0]        fl_alloc_reg;
  logic                      fl_alloc_valid;
  logic [$clog2(FQ_DEPTH):0] fq_count;

  freelist_free_sched #(
    .PR_BITS (PR_BITS),
    .FQ_DEPTH(FQ_DEPTH),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .cm_free_en    (cm_free_en),
    .cm_free_reg0  (cm_free_reg0),
    .cm_free_reg1  (cm_free_reg1),
    .cm_ready      (cm_ready),
    .ren_req       (ren_req),
    .ren_gnt       (ren_gnt),
    .ren_preg      (ren_preg),
    .fl_free_en    (fl_free_en),
    .fl_free_reg   (fl_free_reg),
    .fl_alloc_en   (fl_alloc_en),
    .fl_alloc_reg  (fl_alloc_reg),
    .fl_alloc_valid(fl_alloc_valid),
    .fq_count      (fq_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: pending frees, blocked-cycle budget, freelist port image
  int unsigned q[$];
  bit          m_run;
  int unsigned m_blk;
  bit          m_fe;
  int unsigned m_freg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_run && ((FQ_DEPTH - q.size()) >= 2);
  endfunction

  // Apply one cycle of inputs, check against the model, clock, advance model
  task automatic step(input bit r, input bit f, input logic [1:0] en,
                      input int unsigned r0, input int unsigned r1,
                      input bit req, input bit vld, input int unsigned areg);
    bit gnt;
    rst = r; flush = f; cm_free_en = en;
    cm_free_reg0 = PR_BITS'(r0); cm_free_reg1 = PR_BITS'(r1);
    ren_req = req; fl_alloc_valid = vld; fl_alloc_reg = PR_BITS'(areg);
    #3;
    gnt = req && vld && m_run;
    check("cm_ready",   32'(cm_ready),    32'(m_ready()));
    check("ren_gnt",    32'(ren_gnt),     32'(gnt));
    check("fl_alloc_en", 32'(fl_alloc_en), 32'(gnt));
    if (gnt) check("ren_preg", 32'(ren_preg), areg);
    check("fq_count",   32'(fq_count),    q.size());
    check("fl_free_en", 32'(fl_free_en),  32'(m_fe));
    if (m_fe) check("fl_free_reg", 32'(fl_free_reg), m_freg);
    @(posedge clk);
    if (r) begin
      q.delete(); m_run = 1; m_blk = 0; m_fe = 0; m_freg = 0;
    end else if (f) begin
      q.delete(); m_run = 0; m_blk = HOLD_CYC; m_fe = 0;
    end else begin
      bit rdy;
      rdy = m_ready();
      if (m_run && q.size() > 0) begin
        m_fe = 1; m_freg = q.pop_front();
      end else begin
        m_fe = 0;
      end
      if (rdy && en[0] && r0 != 0) q.push_back(r0);
      if (rdy && en[1] && r1 != 0) q.push_back(r1);
      if (!m_run) begin
        m_blk--;
        if (m_blk == 0) m_run = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned nreg;
    q.delete(); m_run = 1; m_blk = 0; m_fe = 0; m_freg = 0;
    rst = 1; flush = 0; cm_free_en = 0; cm_free_reg0 = 0; cm_free_reg1 = 0;
    ren_req = 0; fl_alloc_valid = 0; fl_alloc_reg = 0;
    @(posedge clk); #1;
    step(1, 0, 2'b00, 0, 0, 0, 0, 0);

    // reset / idle state
    idle(1);
    check("t1_fq_count", 32'(fq_count), 0);
    check("t1_free_en",  32'(fl_free_en), 0);
    check("t1_ready",    32'(cm_ready), 1);
    check("t1_gnt",      32'(ren_gnt), 0);

    // two frees drain in commit order
    step(0, 0, 2'b11, 40, 41, 0, 0, 0);
    check("t2_cnt_a", 32'(fq_count), 2);
    idle(1);
    check("t2_reg_a", 32'(fl_free_reg), 40);
    check("t2_cnt_b", 32'(fq_count), 1);
    idle(1);
    check("t2_reg_b", 32'(fl_free_reg), 41);
    check("t2_cnt_c", 32'(fq_count), 0);
    idle(2);

    // back-to-back double frees until the FIFO backpressures
    nreg = 40;
    for (int i = 0; i < 12; i++) begin
      if (m_ready()) begin
        step(0, 0, 2'b11, nreg, nreg + 1, 0, 0, 0);
        nreg += 2;
      end else begin
        step(0, 0, 2'b00, 0, 0, 0, 0, 0);
      end
    end
    check("t3_full_cnt", 32'(fq_count) >= 32'd6 ? 32'd1 : 32'd0, 1);
    idle(10);
    check("t3_drained", 32'(fq_count), 0);

    // P0 is dropped without consuming a slot
    step(0, 0, 2'b11, 0, 50, 0, 0, 0);
    check("t4_cnt", 32'(fq_count), 1);
    idle(1);
    check("t4_reg", 32'(fl_free_reg), 50);
    idle(2);

    // flush with 3 pending, rename held for HOLD_CYC cycles
    step(0, 0, 2'b11, 1, 2, 0, 0, 0);
    step(0, 0, 2'b11, 3, 4, 0, 0, 0);
    check("t5_cnt3", 32'(fq_count), 3);
    step(0, 1, 2'b00, 0, 0, 1, 1, 32);
    check("t5_flushed", 32'(fq_count), 0);
    check("t5_free_en", 32'(fl_free_en), 0);
    check("t5_hold_a", 32'(ren_gnt), 0);
    step(0, 0, 2'b00, 0, 0, 1, 1, 32);
    check("t5_hold_b", 32'(ren_gnt), 0);
    step(0, 0, 2'b00, 0, 0, 1, 1, 32);
    check("t5_gnt", 32'(ren_gnt), 1);
    check("t5_preg", 32'(ren_preg), 32);

    // flush on last hold cycle restarts the hold
    step(0, 1, 2'b00, 0, 0, 1, 1, 32);
    step(0, 0, 2'b00, 0, 0, 1, 1, 32);
    step(0, 1, 2'b00, 0, 0, 1, 1, 32);
    check("t6_rehold_a", 32'(ren_gnt), 0);
    step(0, 0, 2'b00, 0, 0, 1, 1, 32);
    check("t6_rehold_b", 32'(ren_gnt), 0);
    step(0, 0, 2'b00, 0, 0, 1, 1, 32);
    check("t6_run", 32'(ren_gnt), 1);
    // reset beats flush
    step(1, 1, 2'b00, 0, 0, 1, 1, 7);
    check("t6_rst_pri", 32'(ren_gnt), 1);
    check("t6_rst_rdy", 32'(cm_ready), 1);

    // randomized traffic, protocol-compliant on the commit side
    for (int i = 0; i < 3000; i++) begin
      bit          r, f;
      logic [1:0]  en;
      int unsigned r0, r1;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 39) == 0);
      en = m_ready() ? 2'($urandom) : 2'b00;
      r0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
      r1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
      step(r, f, en, r0, r1, 1'($urandom), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 63));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
